// File: rtl/enum_helpers.sv
// Shared types for the scoreboard issue controller: forward-source encoding,
// per-register producer record and the record ageing helper.
package enum_helpers;

  localparam int REC_LANE_W = 4;

  typedef enum logic [1:0] {
    NONE_f   = 2'd0,
    EX_MEM_f = 2'd1,
    MEM_WB_f = 2'd2,
    INTRA_f  = 2'd3
  } fwd_src_t;

  typedef struct packed {
    logic                  vld;
    logic [1:0]            age;
    logic [REC_LANE_W-1:0] lane;
    logic                  load;
  } sb_rec_t;

  // kill_ex drops an EX-stage producer; adv moves EX->MEM and retires MEM.
  function automatic sb_rec_t age_rec(input sb_rec_t r, input logic kill_ex, input logic adv);
    sb_rec_t n;
    n = r;
    if (kill_ex && r.age == 2'd1) n.vld = 1'b0;
    if (adv) begin
      if (r.age == 2'd2) n.vld = 1'b0;
      else if (r.age == 2'd1) n.age = 2'd2;
    end
    return n;
  endfunction

endpackage

// File: rtl/lane_hazard_check.sv
// Per-lane operand resolution: picks the forward source for rs1/rs2 and flags
// a hazard when the operand cannot be supplied this cycle.
module lane_hazard_check import enum_helpers::*; #(
  parameter int ISSUE_W   = 2,
  parameter int NREG      = 32,
  parameter int INTRA_FWD = 1,
  parameter int LANE      = 0,
  parameter int LW        = 1
) (
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  input  sb_rec_t [NREG-1:0]   recs,
  input  logic [ISSUE_W*5-1:0] rd_vec,
  input  logic [ISSUE_W-1:0]   wb_vec,
  input  logic [ISSUE_W-1:0]   load_vec,
  input  logic [ISSUE_W-1:0]   valid_vec,
  output fwd_src_t             a_src,
  output logic [LW-1:0]        a_lane,
  output fwd_src_t             b_src,
  output logic [LW-1:0]        b_lane,
  output logic                 hazard
);

  logic hz_a;
  logic hz_b;

  function automatic void check_opnd(input logic [4:0] rs, output fwd_src_t src,
                                     output logic [LW-1:0] lsel, output logic hz);
    logic          hit;
    logic [LW-1:0] hit_lane;
    logic          hit_load;
    sb_rec_t       r;
    src      = NONE_f;
    lsel     = '0;
    hz       = 1'b0;
    hit      = 1'b0;
    hit_lane = '0;
    hit_load = 1'b0;
    r        = '0;
    // Ascending scan so the highest lower lane writing rs wins.
    for (int i = 0; i < ISSUE_W; i++) begin
      if (i < LANE && valid_vec[i] && wb_vec[i] && rd_vec[5*i +: 5] == rs) begin
        hit      = 1'b1;
        hit_lane = LW'(i);
        hit_load = load_vec[i];
      end
    end
    if (int'(rs) < NREG) r = recs[rs];
    if (rs != 5'd0) begin
      if (hit) begin
        if (INTRA_FWD != 0 && !hit_load) begin
          src  = INTRA_f;
          lsel = hit_lane;
        end else begin
          hz = 1'b1;
        end
      end else if (r.vld && r.age == 2'd1) begin
        if (r.load) begin
          hz = 1'b1;
        end else begin
          src  = EX_MEM_f;
          lsel = LW'(r.lane);
        end
      end else if (r.vld && r.age == 2'd2) begin
        src  = MEM_WB_f;
        lsel = LW'(r.lane);
      end
    end
  endfunction

  always_comb begin
    check_opnd(rs1, a_src, a_lane, hz_a);
    check_opnd(rs2, b_src, b_lane, hz_b);
    hazard = hz_a | hz_b;
  end

endmodule

// File: rtl/scoreboard_issue_ctrl.sv
// ISSUE_W-wide hazard/issue controller between ID and EX: tracks the youngest
// in-flight writer per register and issues the hazard-free in-order prefix.
module scoreboard_issue_ctrl import enum_helpers::*; #(
  parameter int ISSUE_W   = 2,
  parameter int NREG      = 32,
  parameter int INTRA_FWD = 1,
  parameter int CNT_W     = 32,
  localparam int LW       = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ISSUE_W-1:0]    id_valid,
  input  logic [ISSUE_W*5-1:0]  id_rs1,
  input  logic [ISSUE_W*5-1:0]  id_rs2,
  input  logic [ISSUE_W*5-1:0]  id_rd,
  input  logic [ISSUE_W-1:0]    id_wb,
  input  logic [ISSUE_W-1:0]    id_load,
  input  logic                  ex_ready,
  input  logic                  flush,
  output logic [ISSUE_W-1:0]    issue_mask,
  output logic                  stall,
  output logic [ISSUE_W*2-1:0]  fwd_a_src,
  output logic [ISSUE_W*LW-1:0] fwd_a_lane,
  output logic [ISSUE_W*2-1:0]  fwd_b_src,
  output logic [ISSUE_W*LW-1:0] fwd_b_lane,
  output logic [CNT_W-1:0]      stall_cnt
);

  sb_rec_t [NREG-1:0] rec_reg;
  sb_rec_t [NREG-1:0] rec_next;
  logic [CNT_W-1:0]   stall_cnt_reg;
  logic [ISSUE_W-1:0] hazard;
  logic [ISSUE_W-1:0] issue_ok;
  logic               run;

  genvar gi;
  generate
    for (gi = 0; gi < ISSUE_W; gi++) begin : g_lane
      fwd_src_t      a_src;
      fwd_src_t      b_src;
      logic [LW-1:0] a_lane;
      logic [LW-1:0] b_lane;

      lane_hazard_check #(
        .ISSUE_W  (ISSUE_W),
        .NREG     (NREG),
        .INTRA_FWD(INTRA_FWD),
        .LANE     (gi),
        .LW       (LW)
      ) u_chk (
        .rs1      (id_rs1[5*gi +: 5]),
        .rs2      (id_rs2[5*gi +: 5]),
        .recs     (rec_reg),
        .rd_vec   (id_rd),
        .wb_vec   (id_wb),
        .load_vec (id_load),
        .valid_vec(id_valid),
        .a_src    (a_src),
        .a_lane   (a_lane),
        .b_src    (b_src),
        .b_lane   (b_lane),
        .hazard   (hazard[gi])
      );

      // Forward selects read as NONE/0 while reset is held.
      assign fwd_a_src[2*gi +: 2]   = rst_n ? a_src : NONE_f;
      assign fwd_b_src[2*gi +: 2]   = rst_n ? b_src : NONE_f;
      assign fwd_a_lane[LW*gi +: LW] = rst_n ? a_lane : '0;
      assign fwd_b_lane[LW*gi +: LW] = rst_n ? b_lane : '0;
    end
  endgenerate

  // Invalid lanes pass as bubbles: only a valid lane's hazard breaks the prefix.
  always_comb begin
    issue_ok = '0;
    run      = ex_ready & ~flush & rst_n;
    for (int i = 0; i < ISSUE_W; i++) begin
      run         = run & ~(id_valid[i] & hazard[i]);
      issue_ok[i] = run;
    end
  end

  assign issue_mask = issue_ok & id_valid;
  assign stall      = rst_n & ex_ready & ~flush & (|(id_valid & ~issue_ok));
  assign stall_cnt  = stall_cnt_reg;

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      rec_next[r] = age_rec(rec_reg[r], flush, ex_ready);
    end
    for (int i = 0; i < ISSUE_W; i++) begin
      if (issue_mask[i] && id_wb[i] && id_rd[5*i +: 5] != 5'd0 && int'(id_rd[5*i +: 5]) < NREG) begin
        rec_next[id_rd[5*i +: 5]] = '{vld: 1'b1, age: 2'd1, lane: REC_LANE_W'(i), load: id_load[i]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_reg       <= '0;
      stall_cnt_reg <= '0;
    end else begin
      rec_reg <= rec_next;
      if (stall && !(&stall_cnt_reg)) stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_scoreboard_issue_ctrl.sv
// Bench for scoreboard_issue_ctrl: three configurations share one stimulus and are
// checked every cycle against a pipeline-level model, plus literal directed checks.
module tb_scoreboard_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  v4, wb4, ld4;
  logic [19:0] rs1_4, rs2_4, rd4;
  logic        ex_ready, flush;

  logic [1:0]  u0_mask, u1_mask;
  logic [3:0]  u2_mask;
  logic        u0_stall, u1_stall, u2_stall;
  logic [3:0]  u0_fas, u0_fbs, u1_fas, u1_fbs;
  logic [1:0]  u0_fal, u0_fbl, u1_fal, u1_fbl;
  logic [7:0]  u2_fas, u2_fbs, u2_fal, u2_fbl;
  logic [31:0] u0_cnt, u1_cnt, u2_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  scoreboard_issue_ctrl #(.ISSUE_W(2), .NREG(32), .INTRA_FWD(1), .CNT_W(32)) u0 (
    .clk(clk), .rst_n(rst_n), .id_valid(v4[1:0]), .id_rs1(rs1_4[9:0]), .id_rs2(rs2_4[9:0]),
    .id_rd(rd4[9:0]), .id_wb(wb4[1:0]), .id_load(ld4[1:0]), .ex_ready(ex_ready), .flush(flush),
    .issue_mask(u0_mask), .stall(u0_stall), .fwd_a_src(u0_fas), .fwd_a_lane(u0_fal),
    .fwd_b_src(u0_fbs), .fwd_b_lane(u0_fbl), .stall_cnt(u0_cnt));

  scoreboard_issue_ctrl #(.ISSUE_W(2), .NREG(32), .INTRA_FWD(0), .CNT_W(32)) u1 (
    .clk(clk), .rst_n(rst_n), .id_valid(v4[1:0]), .id_rs1(rs1_4[9:0]), .id_rs2(rs2_4[9:0]),
    .id_rd(rd4[9:0]), .id_wb(wb4[1:0]), .id_load(ld4[1:0]), .ex_ready(ex_ready), .flush(flush),
    .issue_mask(u1_mask), .stall(u1_stall), .fwd_a_src(u1_fas), .fwd_a_lane(u1_fal),
    .fwd_b_src(u1_fbs), .fwd_b_lane(u1_fbl), .stall_cnt(u1_cnt));

  scoreboard_issue_ctrl #(.ISSUE_W(4), .NREG(32), .INTRA_FWD(1), .CNT_W(32)) u2 (
    .clk(clk), .rst_n(rst_n), .id_valid(v4), .id_rs1(rs1_4), .id_rs2(rs2_4),
    .id_rd(rd4), .id_wb(wb4), .id_load(ld4), .ex_ready(ex_ready), .flush(flush),
    .issue_mask(u2_mask), .stall(u2_stall), .fwd_a_src(u2_fas), .fwd_a_lane(u2_fal),
    .fwd_b_src(u2_fbs), .fwd_b_lane(u2_fbl), .stall_cnt(u2_cnt));

  logic [3:0]  act_mask [3];
  logic        act_stall[3];
  logic [31:0] act_cnt  [3];
  logic [7:0]  act_fas[3], act_fal[3], act_fbs[3], act_fbl[3];

  assign act_mask[0] = {2'b00, u0_mask};
  assign act_mask[1] = {2'b00, u1_mask};
  assign act_mask[2] = u2_mask;
  assign act_stall[0] = u0_stall;
  assign act_stall[1] = u1_stall;
  assign act_stall[2] = u2_stall;
  assign act_cnt[0] = u0_cnt;
  assign act_cnt[1] = u1_cnt;
  assign act_cnt[2] = u2_cnt;
  assign act_fas[0] = {4'b0, u0_fas};
  assign act_fas[1] = {4'b0, u1_fas};
  assign act_fas[2] = u2_fas;
  assign act_fbs[0] = {4'b0, u0_fbs};
  assign act_fbs[1] = {4'b0, u1_fbs};
  assign act_fbs[2] = u2_fbs;
  assign act_fal[0] = {6'b0, u0_fal};
  assign act_fal[1] = {6'b0, u1_fal};
  assign act_fal[2] = u2_fal;
  assign act_fbl[0] = {6'b0, u0_fbl};
  assign act_fbl[1] = {6'b0, u1_fbl};
  assign act_fbl[2] = u2_fbl;

  // Model: the bundle currently in EX and the one in MEM, per configuration.
  bit       ex_v [3][4];
  bit [4:0] ex_rd[3][4];
  bit       ex_ld[3][4];
  bit       mem_v [3][4];
  bit [4:0] mem_rd[3][4];
  int unsigned cnt_m[3];

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s inst%0d t=%0t actual=%0d required=%0d", nm, k, $time, act, exp);
    end
  endtask

  task automatic opnd(input int k, input int j, input bit [4:0] rs,
                      output int src, output int ln, output bit hz);
    int p, e, m;
    src = 0; ln = 0; hz = 0; p = -1; e = -1; m = -1;
    if (rs != 0) begin
      for (int i = 0; i < j; i++)
        if (v4[i] && wb4[i] && rd4[5*i +: 5] == rs) p = i;
      for (int i = 0; i < 4; i++) begin
        if (ex_v[k][i] && ex_rd[k][i] == rs) e = i;
        if (mem_v[k][i] && mem_rd[k][i] == rs) m = i;
      end
      if (p >= 0) begin
        if (k != 1 && !ld4[p]) begin src = 3; ln = p; end
        else hz = 1;
      end else if (e >= 0) begin
        if (ex_ld[k][e]) hz = 1;
        else begin src = 1; ln = e; end
      end else if (m >= 0) begin
        src = 2; ln = m;
      end
    end
  endtask

  task automatic model_cycle(input int k);
    int w, lw;
    int a_s[4], a_l[4], b_s[4], b_l[4];
    bit ha[4], hb[4];
    bit run, es;
    bit [3:0] em;
    w  = (k == 2) ? 4 : 2;
    lw = (k == 2) ? 2 : 1;
    if (!rst_n) begin
      chk("rst_mask", k, act_mask[k], 0);
      chk("rst_stall", k, act_stall[k], 0);
      chk("rst_cnt", k, act_cnt[k], 0);
      chk("rst_fwd", k, {act_fas[k], act_fal[k], act_fbs[k], act_fbl[k]}, 0);
      for (int i = 0; i < 4; i++) begin ex_v[k][i] = 0; mem_v[k][i] = 0; end
      cnt_m[k] = 0;
      return;
    end
    for (int j = 0; j < w; j++) begin
      opnd(k, j, rs1_4[5*j +: 5], a_s[j], a_l[j], ha[j]);
      opnd(k, j, rs2_4[5*j +: 5], b_s[j], b_l[j], hb[j]);
    end
    run = ex_ready && !flush;
    em = '0;
    es = 0;
    for (int j = 0; j < w; j++) begin
      run = run && !(v4[j] && (ha[j] || hb[j]));
      em[j] = run && v4[j];
      if (ex_ready && !flush && v4[j] && !run) es = 1;
    end
    chk("mask", k, act_mask[k], em);
    chk("stall", k, act_stall[k], es);
    chk("cnt", k, act_cnt[k], cnt_m[k]);
    for (int j = 0; j < w; j++) begin
      if (!ha[j]) begin
        chk($sformatf("a_src%0d", j), k, (act_fas[k] >> (2*j)) & 8'h3, a_s[j]);
        chk($sformatf("a_lane%0d", j), k, (act_fal[k] >> (lw*j)) & ((8'h1 << lw) - 1), a_l[j]);
      end
      if (!hb[j]) begin
        chk($sformatf("b_src%0d", j), k, (act_fbs[k] >> (2*j)) & 8'h3, b_s[j]);
        chk($sformatf("b_lane%0d", j), k, (act_fbl[k] >> (lw*j)) & ((8'h1 << lw) - 1), b_l[j]);
      end
    end
    if (es && cnt_m[k] != 32'hFFFF_FFFF) cnt_m[k]++;
    if (flush) begin
      // A MEM writer hidden behind a younger EX writer of the same register is forgotten.
      for (int i = 0; i < 4; i++)
        for (int e = 0; e < 4; e++)
          if (mem_v[k][i] && ex_v[k][e] && ex_rd[k][e] == mem_rd[k][i]) mem_v[k][i] = 0;
      for (int i = 0; i < 4; i++) ex_v[k][i] = 0;
    end
    if (ex_ready) begin
      for (int i = 0; i < 4; i++) begin
        mem_v[k][i]  = ex_v[k][i];
        mem_rd[k][i] = ex_rd[k][i];
        ex_v[k][i]   = (i < w) && em[i] && wb4[i] && (rd4[5*i +: 5] != 0);
        ex_rd[k][i]  = rd4[5*i +: 5];
        ex_ld[k][i]  = ld4[i];
      end
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) model_cycle(k);
  end

  task automatic clear_lanes();
    v4 = '0; wb4 = '0; ld4 = '0; rs1_4 = '0; rs2_4 = '0; rd4 = '0;
  endtask

  task automatic set_lane(input int l, input bit v, input bit [4:0] a, input bit [4:0] b,
                          input bit [4:0] d, input bit w, input bit ld);
    v4[l] = v; rs1_4[5*l +: 5] = a; rs2_4[5*l +: 5] = b; rd4[5*l +: 5] = d;
    wb4[l] = w; ld4[l] = ld;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    clear_lanes();
    ex_ready = 1; flush = 0;
    repeat (n) begin sample(); next(); end
  endtask

  initial begin
    rst_n = 0; ex_ready = 1; flush = 0;
    clear_lanes();
    // Reset with two independent lanes presented
    set_lane(0, 1, 2, 3, 1, 1, 0);
    set_lane(1, 1, 10, 11, 8, 1, 0);
    sample();
    chk("t1_rst_mask", 0, u0_mask, 0);
    chk("t1_rst_cnt", 0, u0_cnt, 0);
    next();
    rst_n = 1;
    sample();
    chk("t1_mask", 0, u0_mask, 2'b11);
    next();
    idle(3);

    // Intra-bundle chain x5 -> x6
    set_lane(0, 1, 20, 21, 5, 1, 0);
    set_lane(1, 1, 5, 22, 6, 1, 0);
    sample();
    chk("t2_mask_intra", 0, u0_mask, 2'b11);
    chk("t2_a_src1", 0, u0_fas[3:2], 3);
    chk("t2_a_lane1", 0, u0_fal[1], 0);
    chk("t2_mask_split", 1, u1_mask, 2'b01);
    chk("t2_stall_split", 1, u1_stall, 1);
    next();
    idle(3);

    // Load-use
    clear_lanes();
    set_lane(1, 1, 26, 27, 7, 1, 1);
    sample(); next();
    clear_lanes();
    set_lane(0, 1, 7, 28, 0, 0, 0);
    sample();
    chk("t3_stall", 0, u0_stall, 1);
    chk("t3_mask", 0, u0_mask, 2'b00);
    next();
    sample();
    chk("t3_cnt", 0, u0_cnt, 1);
    chk("t3_a_src0", 0, u0_fas[1:0], 2);
    chk("t3_a_lane0", 0, u0_fal[0], 1);
    next();
    idle(3);

    // EX_MEM then MEM_WB then NONE
    clear_lanes();
    set_lane(0, 1, 23, 24, 9, 1, 0);
    sample(); next();
    set_lane(0, 1, 26, 27, 11, 1, 0);
    set_lane(1, 1, 25, 9, 10, 1, 0);
    sample();
    chk("t4_b_src1", 0, u0_fbs[3:2], 1);
    chk("t4_b_lane1", 0, u0_fbl[1], 0);
    chk("t4_mask", 0, u0_mask, 2'b11);
    next();
    clear_lanes();
    set_lane(1, 1, 25, 9, 0, 0, 0);
    sample();
    chk("t4_b_src1_memwb", 0, u0_fbs[3:2], 2);
    next();
    sample();
    chk("t4_b_src1_none", 0, u0_fbs[3:2], 0);
    next();
    idle(3);

    // Freeze then flush
    clear_lanes();
    set_lane(0, 1, 12, 13, 3, 1, 0);
    sample(); next();
    ex_ready = 0;
    set_lane(0, 1, 3, 14, 0, 0, 0);
    repeat (3) begin
      sample();
      chk("t5_frozen_src", 0, u0_fas[1:0], 1);
      chk("t5_frozen_stall", 0, u0_stall, 0);
      next();
    end
    ex_ready = 1; flush = 1;
    sample();
    chk("t5_flush_mask", 0, u0_mask, 2'b00);
    next();
    flush = 0;
    sample();
    chk("t5_after_flush", 0, u0_fas[1:0], 0);
    next();
    idle(3);

    // Same rd in both lanes, x0 reads
    clear_lanes();
    set_lane(0, 1, 15, 16, 4, 1, 0);
    set_lane(1, 1, 0, 17, 4, 1, 0);
    sample();
    chk("t6_x0_a1", 0, u0_fas[3:2], 0);
    next();
    clear_lanes();
    set_lane(0, 1, 4, 0, 0, 0, 0);
    sample();
    chk("t6_a_src0", 0, u0_fas[1:0], 1);
    chk("t6_a_lane0", 0, u0_fal[0], 1);
    chk("t6_x0_b0", 0, u0_fbs[1:0], 0);
    next();
    idle(3);

    // Four lanes, load in lane 0 feeding lane 2
    clear_lanes();
    set_lane(0, 1, 1, 2, 12, 1, 1);
    set_lane(1, 1, 3, 18, 13, 1, 0);
    set_lane(2, 1, 12, 19, 14, 1, 0);
    set_lane(3, 1, 20, 21, 15, 1, 0);
    sample();
    chk("t7_mask4", 2, u2_mask, 4'b0011);
    chk("t7_stall4", 2, u2_stall, 1);
    next();
    idle(3);

    // Randomised traffic with occasional flush and reset
    repeat (3000) begin
      for (int l = 0; l < 4; l++)
        set_lane(l, ($urandom_range(3) != 0), 5'($urandom_range(7)), 5'($urandom_range(7)),
                 5'($urandom_range(7)), ($urandom_range(9) < 7), ($urandom_range(3) == 0));
      ex_ready = ($urandom_range(4) != 0);
      flush    = ($urandom_range(11) == 0);
      rst_n    = ($urandom_range(99) != 0);
      sample();
      next();
    end
    rst_n = 1;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
